// File: rtl/answer_display_driver_if.sv
// ---------------------------------------------------------------------------
// answer_display_driver_if
//   Bundles the calculator result input and the multiplexed 7-segment
//   display outputs of answer_display_driver.
//
//   Optional: when DISPLAY_HEX_EN is defined, a hex_mode input is added
//   right after answer.
//
//   Signals:
//     answer    [31:0]            signed result from the calculator core
//     hex_mode                    raw hex display select (DISPLAY_HEX_EN only)
//     an        [NUM_DIGITS-1:0]  digit enables, active-low, bit 0 rightmost
//     seg       [6:0]             segments {g,f,e,d,c,b,a}, active-low
//     dp                          decimal point, active-low (always off)
//     busy                        conversion in progress
//     overflow                    displayed value out of range
//
//   Modports:
//     master  calculator/board side (drives answer, reads the display)
//     slave   display driver side
// ---------------------------------------------------------------------------
interface answer_display_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [31:0]           answer;
`ifdef DISPLAY_HEX_EN
  logic                  hex_mode;
`endif
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  busy;
  logic                  overflow;

  modport master (
    output answer,
`ifdef DISPLAY_HEX_EN
    output hex_mode,
`endif
    input  an,
    input  seg,
    input  dp,
    input  busy,
    input  overflow
  );

  modport slave (
    input  answer,
`ifdef DISPLAY_HEX_EN
    input  hex_mode,
`endif
    output an,
    output seg,
    output dp,
    output busy,
    output overflow
  );
endinterface

// File: rtl/answer_display_driver.sv
// ---------------------------------------------------------------------------
// answer_display_driver
//   Takes the signed 32-bit result of the calculator core, converts it to
//   BCD with a sequential double-dabble engine, applies leading-zero blanking
//   and minus-sign placement, flags overflow, and scans the digits of a
//   common-anode multiplexed 7-segment display.
//
//   Optional feature macro: DISPLAY_HEX_EN
//     Adds bus.hex_mode. While it is high the display shows the low
//     4*NUM_DIGITS bits of answer as raw hex nibbles (no blanking, no sign,
//     overflow low). The decimal engine keeps running in the background and
//     its last completed result reappears when hex_mode drops.
//
//   Parameters:
//     NUM_DIGITS   number of physical digits, 2..8
//     REFRESH_DIV  clock cycles each digit stays enabled during the scan
//
//   Ports:
//     clk    system clock
//     reset  synchronous reset, active-high
//     bus    answer_display_driver_if.slave (answer in, display/status out)
//
//   FSM states:
//     state | meaning
//     IDLE  | waiting for answer to differ from the last converted value
//     CONV  | 32 double-dabble iterations (add-3 then shift)
//     LOAD  | build digit codes from the BCD result into display registers
// ---------------------------------------------------------------------------
module answer_display_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  answer_display_driver_if.slave bus
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] answer_q;
  logic [31:0] last_value;
  logic        sign;
  logic [31:0] mag;
  logic [39:0] bcd;
  logic [39:0] bcd_adj;
  logic [71:0] dd_shift;
  logic [4:0]  iter;
  logic [31:0] mag_abs;
  logic        changed;

  logic [NUM_DIGITS-1:0][6:0] disp;
  logic [NUM_DIGITS-1:0][6:0] dec_new;
  logic                       ovf_new;
  logic                       ovf_q;

  logic [CW-1:0]         rcnt;
  logic [IW-1:0]         idx;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // answer is registered once before the compare, so a change seen at one
  // edge starts the conversion on the following edge.
  assign changed = (answer_q != last_value);

  // Two's-complement negate of 0x80000000 yields 0x80000000, which read as
  // unsigned is exactly 2^31, so 32 bits hold every magnitude.
  assign mag_abs = answer_q[31] ? (32'd0 - answer_q) : answer_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (changed) state_nxt = CONV;
      CONV:    if (iter == 5'd0) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

  // ------------------------------------------------------- double dabble
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign dd_shift = {bcd_adj, mag} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      answer_q   <= '0;
      last_value <= '0;
      sign       <= 1'b0;
      mag        <= '0;
      bcd        <= '0;
      iter       <= '0;
    end else begin
      answer_q <= bus.answer;
      case (state)
        IDLE: begin
          if (changed) begin
            last_value <= answer_q;
            sign       <= answer_q[31];
            mag        <= mag_abs;
            bcd        <= '0;
            iter       <= 5'd31;
          end
        end
        CONV: begin
          bcd  <= dd_shift[71:32];
          mag  <= dd_shift[31:0];
          iter <= iter - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------ digit code formation
  // Overflow is judged on the BCD digits: a positive value may use all
  // NUM_DIGITS places, a negative one must leave the top place for '-'.
  always_comb begin
    int msd;
    ovf_new = 1'b0;
    msd     = 0;
    dec_new = '0;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        if (i >= NUM_DIGITS)             ovf_new = 1'b1;
        if (sign && i >= NUM_DIGITS - 1) ovf_new = 1'b1;
        if (i < NUM_DIGITS)              msd     = i;
      end
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (ovf_new)
        dec_new[k] = (k == 0) ? SEG_E : SEG_BLANK;
      else if (k <= msd)
        dec_new[k] = seg_of(bcd[4*k +: 4]);
      else if (sign && k == msd + 1)
        dec_new[k] = SEG_MINUS;
      else
        dec_new[k] = SEG_BLANK;
    end
  end

  // ---------------------------------------------------- display registers
`ifdef DISPLAY_HEX_EN
  logic [NUM_DIGITS-1:0][6:0] dec_disp;
  logic                       dec_ovf;
  logic [NUM_DIGITS-1:0][6:0] hex_new;

  always_comb begin
    hex_new = '0;
    for (int k = 0; k < NUM_DIGITS; k++) hex_new[k] = seg_of(bus.answer[4*k +: 4]);
  end

  // The decimal result is kept separately so leaving hex mode restores it
  // without a reconversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        disp[k]     <= (k == 0) ? SEG_0 : SEG_BLANK;
        dec_disp[k] <= (k == 0) ? SEG_0 : SEG_BLANK;
      end
      ovf_q   <= 1'b0;
      dec_ovf <= 1'b0;
    end else begin
      if (state == LOAD) begin
        dec_disp <= dec_new;
        dec_ovf  <= ovf_new;
      end
      if (bus.hex_mode) begin
        disp  <= hex_new;
        ovf_q <= 1'b0;
      end else if (state == LOAD) begin
        disp  <= dec_new;
        ovf_q <= ovf_new;
      end else begin
        disp  <= dec_disp;
        ovf_q <= dec_ovf;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) disp[k] <= (k == 0) ? SEG_0 : SEG_BLANK;
      ovf_q <= 1'b0;
    end else if (state == LOAD) begin
      disp  <= dec_new;
      ovf_q <= ovf_new;
    end
  end
`endif

  assign bus.overflow = ovf_q;

  // ----------------------------------------------------------------- scan
  always_comb begin
    an_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) an_nxt[k] = (idx != IW'(k));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt  <= '0;
      idx   <= '0;
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      if (rcnt == CW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
      an_q  <= an_nxt;
      seg_q <= disp[idx];
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_answer_display_driver.sv
// Self-checking bench for answer_display_driver (8 digits, 4-cycle slots).
module tb_answer_display_driver;
  localparam int ND = 8;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  answer_display_driver_if #(.NUM_DIGITS(ND)) bus ();

  answer_display_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string            name;
    logic [31:0]      answer;
    logic             ovf;
    logic [7:0][6:0]  segs;   // digit 7 .. digit 0
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string tag, input logic val, input int max);
    int c = 0;
    while (bus.busy !== val && c < max) begin
      tick();
      c++;
    end
    chk($sformatf("%s busy->%0b", tag, val), {31'd0, bus.busy}, {31'd0, val});
  endtask

  task automatic check_digit(input string tag, input int k, input logic [6:0] exp);
    logic [7:0] one;
    logic [7:0] want;
    int c = 0;
    one  = 8'd1;
    want = ~(one << k);
    while (bus.an !== want && c < 40) begin
      tick();
      c++;
    end
    chk($sformatf("%s an slot%0d", tag, k), {24'd0, bus.an}, {24'd0, want});
    chk($sformatf("%s seg%0d", tag, k), {25'd0, bus.seg}, {25'd0, exp});
  endtask

  initial begin
    int len;

    vecs[0] = '{"pos_1234", 32'd1234, 1'b0,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{"neg_56", 32'hFFFFFFC8, 1'b0,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h12, 7'h02}};
    vecs[2] = '{"ovf_1e8", 32'd100000000, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06}};
    vecs[3] = '{"ovf_min", 32'h80000000, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06}};
    vecs[4] = '{"max_pos", 32'd99999999, 1'b0,
                {7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[5] = '{"max_neg", -32'sd9999999, 1'b0,
                {7'h3F, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[6] = '{"ovf_neg", -32'sd10000000, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06}};
    vecs[7] = '{"zero", 32'd0, 1'b0,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[8] = '{"neg_1", 32'hFFFFFFFF, 1'b0,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h79}};
    vecs[9] = '{"mix_9087", 32'd9087, 1'b0,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h40, 7'h00, 7'h78}};

    bus.answer = 32'd0;
`ifdef DISPLAY_HEX_EN
    bus.hex_mode = 1'b0;
`endif

    // ---- reset state and blank scan
    reset = 1'b1;
    repeat (3) tick();
    chk("rst an", {24'd0, bus.an}, 32'h000000FF);
    chk("rst seg", {25'd0, bus.seg}, 32'h7F);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst dp", {31'd0, bus.dp}, 32'd1);
    reset = 1'b0;
    tick();
    chk("first slot an", {24'd0, bus.an}, 32'h000000FE);
    chk("first slot seg", {25'd0, bus.seg}, 32'h40);
    len = 1;
    while (len < 20) begin
      tick();
      if (bus.an === 8'hFE) len++;
      else break;
    end
    chk("slot length", len, 32'd4);
    chk("slot1 an", {24'd0, bus.an}, 32'h000000FD);
    chk("slot1 seg", {25'd0, bus.seg}, 32'h7F);
    chk("idle busy", {31'd0, bus.busy}, 32'd0);

    // ---- 5 then 7 during the conversion: back-to-back timing
    bus.answer = 32'd5;
    for (int c = 0; c <= 35; c++) begin
      tick();
      if (c == 9) bus.answer = 32'd7;
      if (c == 0)  chk("b2b busy@T", {31'd0, bus.busy}, 32'd0);
      if (c == 1)  chk("b2b busy@T+1", {31'd0, bus.busy}, 32'd1);
      if (c == 33) chk("b2b busy@T+33", {31'd0, bus.busy}, 32'd1);
      if (c == 34) chk("b2b busy@T+34", {31'd0, bus.busy}, 32'd0);
      if (c == 35) chk("b2b busy@T+35", {31'd0, bus.busy}, 32'd1);
    end
    check_digit("b2b first", 0, 7'h12);
    wait_busy("b2b", 1'b0, 40);
    tick();
    check_digit("b2b second", 0, 7'h78);
    check_digit("b2b second", 1, 7'h7F);

    // ---- table of values
    foreach (vecs[i]) begin
      bus.answer = vecs[i].answer;
      wait_busy(vecs[i].name, 1'b1, 5);
      wait_busy(vecs[i].name, 1'b0, 40);
      tick();
      chk({vecs[i].name, " ovf"}, {31'd0, bus.overflow}, {31'd0, vecs[i].ovf});
      for (int k = 0; k < ND; k++) check_digit(vecs[i].name, k, vecs[i].segs[k]);
    end

    // ---- reset in the middle of converting 99
    bus.answer = 32'd99;
    tick();
    repeat (14) tick();
    chk("midrst busy before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("midrst busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst an", {24'd0, bus.an}, 32'h000000FF);
    chk("midrst ovf", {31'd0, bus.overflow}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst slot0 an", {24'd0, bus.an}, 32'h000000FE);
    chk("midrst slot0 seg", {25'd0, bus.seg}, 32'h40);
    wait_busy("midrst", 1'b1, 5);
    wait_busy("midrst", 1'b0, 40);
    tick();
    check_digit("midrst 99", 0, 7'h10);
    check_digit("midrst 99", 1, 7'h10);
    check_digit("midrst 99", 2, 7'h7F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
